wb_stage: RTL and testbench

Writeback stage that sits directly downstream of the MEM/WB pipeline register and closes the loop back to decode. Each cycle it selects the writeback value, which is either memory load data or the ALU/address result. It commits that value into the 32-entry integer register file and serves the two decode-stage read ports. It also exposes the writeback value and a committed-write counter for the forwarding unit and debug.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/reg_file.sv | 41 ++++
 rtl/wb_stage.sv | 66 ++++++
 tb/tb_wb_stage.sv | 120 ++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared integer-pipeline definitions used by the writeback stage and register file.
package riscv_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Same bit layout as the WB field of the MEM/WB register: bit 1 = Reg_Write, bit 0 = Mem_to_Reg.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

endpackage

// File: rtl/reg_file.sv
// Integer register file: synchronous clear, one write port, two asynchronous read ports.
// Build with WB_BYPASS_EN to forward the in-flight write to same-cycle reads.
module reg_file #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] regs_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // x0 is hardwired to zero on the read side regardless of what storage holds.
  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    if (raddr1_i != '0) rdata1_o = regs_q[raddr1_i];
    if (raddr2_i != '0) rdata2_o = regs_q[raddr2_i];
`ifdef WB_BYPASS_EN
    if (!reset && we_i && (raddr1_i != '0) && (raddr1_i == waddr_i)) rdata1_o = wdata_i;
    if (!reset && we_i && (raddr2_i != '0) && (raddr2_i == waddr_i)) rdata2_o = wdata_i;
`endif
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: selects load vs ALU result, commits to the register file, counts commits.
// Optional WB_BYPASS_EN enables write-through from the writeback value to the decode read ports.
module wb_stage #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NREGS,
  parameter int AW    = riscv_pkg::REG_ADDR_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Mem_to_Reg,
  input  logic             Reg_Write,
  input  logic [XLEN-1:0]  Read_Data,
  input  logic [XLEN-1:0]  Mem_Address,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic [XLEN-1:0]  Read_Data1,
  output logic [XLEN-1:0]  Read_Data2,
  output logic [XLEN-1:0]  Write_Data_out,
  output logic             Write_En_out,
  output logic [CNT_W-1:0] Wb_Count
);
  import riscv_pkg::*;

  wb_ctrl_t         ctrl;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign ctrl           = '{reg_write: Reg_Write, mem_to_reg: Mem_to_Reg};
  assign Write_Data_out = ctrl.mem_to_reg ? Read_Data : Mem_Address;
  assign Write_En_out   = ctrl.reg_write && (rd != '0) && !reset;

  always_comb begin
    cnt_d = cnt_q;
    if (Write_En_out) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign Wb_Count = cnt_q;

  // An unknown write enable outside reset would scribble X into storage.
  always_ff @(posedge clk) begin
    if (!reset) assert (!$isunknown(Reg_Write));
  end

  reg_file #(
    .DATA_W (XLEN),
    .DEPTH  (NREGS),
    .ADDR_W (AW)
  ) u_reg_file (
    .clk      (clk),
    .reset    (reset),
    .we_i     (Write_En_out),
    .waddr_i  (rd),
    .wdata_i  (Write_Data_out),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (Read_Data1),
    .rdata2_o (Read_Data2)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage; counter built 4 bits wide to exercise wrap quickly.
module tb_wb_stage;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          Mem_to_Reg, Reg_Write;
  logic [63:0]   Read_Data, Mem_Address;
  logic [4:0]    rd, rs1, rs2;
  logic [63:0]   Read_Data1, Read_Data2, Write_Data_out;
  logic          Write_En_out;
  logic [CW-1:0] Wb_Count;

  wb_stage #(.XLEN(64), .NREGS(32), .AW(5), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Mem_to_Reg(Mem_to_Reg), .Reg_Write(Reg_Write),
    .Read_Data(Read_Data), .Mem_Address(Mem_Address), .rd(rd), .rs1(rs1), .rs2(rs2),
    .Read_Data1(Read_Data1), .Read_Data2(Read_Data2), .Write_Data_out(Write_Data_out),
    .Write_En_out(Write_En_out), .Wb_Count(Wb_Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] wd;
    logic        we;
    logic [63:0] r1;
    logic [63:0] r2;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb_q[$];
  logic [63:0]   mregs [32];
  logic [CW-1:0] mcnt;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle, push expectations, compare at negedge, then advance the model past the edge.
  task automatic cycle(input string tag, input logic rst, input logic rw, input logic m2r,
                       input logic [63:0] rdat, input logic [63:0] addr,
                       input logic [4:0] d, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e, o;
    reset = rst; Reg_Write = rw; Mem_to_Reg = m2r;
    Read_Data = rdat; Mem_Address = addr; rd = d; rs1 = a1; rs2 = a2;
    e.tag = tag;
    e.wd  = m2r ? rdat : addr;
    e.we  = rw && (d != 5'd0) && !rst;
    e.r1  = (a1 == 5'd0) ? 64'd0 : mregs[a1];
    e.r2  = (a2 == 5'd0) ? 64'd0 : mregs[a2];
`ifdef WB_BYPASS_EN
    if (e.we && a1 == d) e.r1 = e.wd;
    if (e.we && a2 == d) e.r2 = e.wd;
`endif
    e.cnt = mcnt;
    sb_q.push_back(e);
    @(negedge clk);
    o = sb_q.pop_front();
    chk({o.tag, ".wd"},  Write_Data_out, o.wd);
    chk({o.tag, ".we"},  {63'd0, Write_En_out}, {63'd0, o.we});
    chk({o.tag, ".rd1"}, Read_Data1, o.r1);
    chk({o.tag, ".rd2"}, Read_Data2, o.r2);
    chk({o.tag, ".cnt"}, {60'd0, Wb_Count}, {60'd0, o.cnt});
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
      mcnt = '0;
    end else if (e.we) begin
      mregs[d] = e.wd;
      mcnt = mcnt + 1'b1;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; Reg_Write = 1'b0; Mem_to_Reg = 1'b0;
    Read_Data = '0; Mem_Address = '0; rd = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
    mcnt = '0;

    // Random writes, then a two-cycle reset carrying a write to x3.
    for (int i = 0; i < 8; i++)
      cycle("rand", 1'b0, 1'b1, i[0], {$urandom, $urandom}, {$urandom, $urandom},
            5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    cycle("rst0", 1'b1, 1'b1, 1'b0, 64'd0, 64'hABCD, 5'd3, 5'd3, 5'd4);
    cycle("rst1", 1'b1, 1'b1, 1'b0, 64'd0, 64'hABCD, 5'd3, 5'd3, 5'd4);
    for (int i = 0; i < 32; i += 2)
      cycle("clr", 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'(i), 5'(i + 1));

    cycle("alu",    1'b0, 1'b1, 1'b0, 64'h0, 64'hDEAD_BEEF_0000_0001, 5'd5, 5'd0, 5'd0);
    cycle("alu_rd", 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd5, 5'd0);
    cycle("load",   1'b0, 1'b1, 1'b1, 64'h1234, 64'hFFFF, 5'd31, 5'd0, 5'd0);
    cycle("load_rd",1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd31, 5'd31);
    cycle("x0",     1'b0, 1'b1, 1'b0, 64'h0, 64'h55, 5'd0, 5'd0, 5'd0);
    cycle("x0_rd",  1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd5, 5'd0);

    cycle("rdw_old", 1'b0, 1'b1, 1'b0, 64'h0, 64'd1, 5'd7, 5'd0, 5'd0);
    cycle("rdw",     1'b0, 1'b1, 1'b0, 64'h0, 64'd2, 5'd7, 5'd7, 5'd7);
    cycle("rdw_nxt", 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd7, 5'd7);

    // Seventeen back-to-back commits carry the 4-bit counter through 15 -> 0 -> 1.
    for (int i = 0; i < 17; i++)
      cycle("wrap", 1'b0, 1'b1, 1'b0, 64'h0, 64'(100 + i), 5'(1 + (i % 31)), 5'(1 + (i % 31)), 5'd31);
    cycle("wrap_end", 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd17, 5'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
